// File: rtl/cc_game_pkg.sv
// Shared definitions for the road-game obstacle logic: row-bank state
// encodings, LFSR seed and taps, and the default row width.
package cc_game_pkg;

  typedef enum logic [1:0] {
    CBR_IDLE  = 2'd0,
    CBR_SHIFT = 2'd1,
    CBR_CHECK = 2'd2,
    CBR_CRASH = 2'd3
  } cbr_state_t;

  localparam logic [7:0] CBR_LFSR_SEED = 8'hA5;
  // Taps at bits 7, 5, 4 and 3 (maximal-length 8-bit sequence).
  localparam logic [7:0] CBR_LFSR_TAPS = 8'b1011_1000;
  localparam int         CBR_ROW_WIDTH = 8;

  // Feedback bit for a left-shifting Fibonacci LFSR.
  function automatic logic lfsr_feedback(input logic [7:0] state);
    return ^(state & CBR_LFSR_TAPS);
  endfunction

  // Column index of a spawned car; only meaningful when spawn_car() is set.
  function automatic logic [2:0] spawn_column(input logic [7:0] state);
    return state[2:0];
  endfunction

  // A car is spawned only when the LFSR MSB is set.
  function automatic logic spawn_car(input logic [7:0] state);
    return state[7];
  endfunction

endpackage

// File: rtl/cc_lfsr8.sv
// 8-bit Fibonacci LFSR, shifting left, loaded with a seed on reset and
// advanced one step per cycle while enabled.
module cc_lfsr8
  import cc_game_pkg::*;
#(
  parameter logic [7:0] SEED = CBR_LFSR_SEED
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic [7:0] o_state
);

  logic [7:0] r_state;

  // Advance the sequence when enabled; hold otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= {r_state[6:0], lfsr_feedback(r_state)};
    end else begin
      r_state <= r_state;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/cc_back_rows.sv
// Background obstacle-row bank: scrolls a stack of car rows on each load
// strobe, injects a pseudo-random row at the top, checks the bottom row
// against the player and counts cars that pass safely.
module cc_back_rows
  import cc_game_pkg::*;
#(
  parameter int RDATAWIDTH = CBR_ROW_WIDTH,
  parameter int ROWADDR    = 3
) (
  input  logic                  CC_BackRows_CLOCK_50,
  input  logic                  CC_BackRows_RESET_InHigh,
  input  logic                  CC_BackRows_load_InLow,
  input  logic [RDATAWIDTH-1:0] Player_CC_BackRows_data_InBUS,
  input  logic [ROWADDR-1:0]    CC_BackRows_RowSel_In,
  output logic [RDATAWIDTH-1:0] CC_BackRows_Row_OutBUS,
  output logic                  CC_BackRows_Collision_OutHigh,
  output logic [7:0]            CC_BackRows_Score_OutBUS
);

  localparam int NROWS = 1 << ROWADDR;

  cbr_state_t            r_state;
  logic                  r_load_prev;
  logic [RDATAWIDTH-1:0] r_rows [NROWS];
  logic                  r_collision;
  logic [7:0]            r_score;

  logic [7:0]            w_lfsr;
  logic                  w_lfsr_en;
  logic                  w_load_req;
  logic [RDATAWIDTH-1:0] w_pattern;

  // The generator only steps in the cycle that consumes its value.
  assign w_lfsr_en  = (r_state == CBR_SHIFT);
  // Falling edge of the active-low strobe; a held low level requests once.
  assign w_load_req = r_load_prev & ~CC_BackRows_load_InLow;

  cc_lfsr8 #(
    .SEED (CBR_LFSR_SEED)
  ) u_lfsr (
    .i_clk   (CC_BackRows_CLOCK_50),
    .i_rst   (CC_BackRows_RESET_InHigh),
    .i_en    (w_lfsr_en),
    .o_state (w_lfsr)
  );

  // New top row: a single car at the LFSR-selected column, or an empty row.
  always_comb begin
    w_pattern = {RDATAWIDTH{1'b0}};
    if (spawn_car(w_lfsr)) begin
      w_pattern = {{(RDATAWIDTH-1){1'b0}}, 1'b1} << spawn_column(w_lfsr);
    end else begin
      w_pattern = {RDATAWIDTH{1'b0}};
    end
  end

  // Strobe edge history: tracked in every state so requests arriving while
  // busy are consumed rather than deferred.
  always_ff @(posedge CC_BackRows_CLOCK_50 or posedge CC_BackRows_RESET_InHigh) begin
    if (CC_BackRows_RESET_InHigh) begin
      r_load_prev <= 1'b1;
    end else begin
      r_load_prev <= CC_BackRows_load_InLow;
    end
  end

  // Sequencer: scroll rows, score departing cars, check the bottom row and
  // latch a crash, which freezes the bank until reset.
  always_ff @(posedge CC_BackRows_CLOCK_50 or posedge CC_BackRows_RESET_InHigh) begin
    if (CC_BackRows_RESET_InHigh) begin
      r_state     <= CBR_IDLE;
      r_collision <= 1'b0;
      r_score     <= 8'd0;
      for (int i = 0; i < NROWS; i++) begin
        r_rows[i] <= {RDATAWIDTH{1'b0}};
      end
    end else begin
      case (r_state)
        CBR_IDLE: begin
          if (w_load_req) begin
            r_state <= CBR_SHIFT;
          end else begin
            r_state <= CBR_IDLE;
          end
        end
        CBR_SHIFT: begin
          for (int i = NROWS - 1; i > 0; i--) begin
            r_rows[i] <= r_rows[i-1];
          end
          r_rows[0] <= w_pattern;
          if ((r_rows[NROWS-1] != {RDATAWIDTH{1'b0}}) && (r_score != 8'hFF)) begin
            r_score <= r_score + 8'd1;
          end else begin
            r_score <= r_score;
          end
          r_state <= CBR_CHECK;
        end
        CBR_CHECK: begin
          if ((r_rows[NROWS-1] & Player_CC_BackRows_data_InBUS) != {RDATAWIDTH{1'b0}}) begin
            r_collision <= 1'b1;
            r_state     <= CBR_CRASH;
          end else begin
            r_state     <= CBR_IDLE;
          end
        end
        CBR_CRASH: begin
          r_state     <= CBR_CRASH;
          r_collision <= 1'b1;
        end
        default: begin
          r_state <= CBR_IDLE;
        end
      endcase
    end
  end

  assign CC_BackRows_Row_OutBUS        = r_rows[CC_BackRows_RowSel_In];
  assign CC_BackRows_Collision_OutHigh = r_collision;
  assign CC_BackRows_Score_OutBUS      = r_score;

endmodule

// File: tb/tb_cc_back_rows.sv
// Self-checking bench for cc_back_rows: a behavioural model of the row bank
// pushes expected state to a scoreboard per accepted load; the result is
// popped and compared once the DUT has completed the load sequence.
`timescale 1ns/100ps
module tb_cc_back_rows;

  localparam int RW = 8;
  localparam int RA = 3;
  localparam int NR = 1 << RA;

  logic          clk;
  logic          rst;
  logic          load_n;
  logic [RW-1:0] player;
  logic [RA-1:0] rowsel;
  logic [RW-1:0] row_out;
  logic          coll;
  logic [7:0]    score;

  typedef struct {
    logic [RW-1:0] rows [NR];
    logic [7:0]    score;
    logic          coll;
  } exp_t;

  exp_t sb [$];

  logic [RW-1:0] m_rows [NR];
  logic [7:0]    m_lfsr;
  logic [7:0]    m_score;
  logic          m_crash;

  int n_err = 0;
  int n_chk = 0;

  cc_back_rows #(.RDATAWIDTH(RW), .ROWADDR(RA)) dut (
    .CC_BackRows_CLOCK_50          (clk),
    .CC_BackRows_RESET_InHigh      (rst),
    .CC_BackRows_load_InLow        (load_n),
    .Player_CC_BackRows_data_InBUS (player),
    .CC_BackRows_RowSel_In         (rowsel),
    .CC_BackRows_Row_OutBUS        (row_out),
    .CC_BackRows_Collision_OutHigh (coll),
    .CC_BackRows_Score_OutBUS      (score)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_rows[i] = 8'h00;
    m_lfsr  = 8'hA5;
    m_score = 8'd0;
    m_crash = 1'b0;
  endtask

  // Reference behaviour of one accepted load (shift + check).
  task automatic model_load();
    logic [7:0] depart;
    logic       fb;
    if (!m_crash) begin
      depart = m_rows[NR-1];
      for (int i = NR - 1; i > 0; i--) m_rows[i] = m_rows[i-1];
      m_rows[0] = m_lfsr[7] ? (8'h01 << m_lfsr[2:0]) : 8'h00;
      fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
      m_lfsr = {m_lfsr[6:0], fb};
      if (depart != 8'h00 && m_score != 8'hFF) m_score = m_score + 8'd1;
      if ((m_rows[NR-1] & player) != 8'h00) m_crash = 1'b1;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < NR; i++) e.rows[i] = m_rows[i];
    e.score = m_score;
    e.coll  = m_crash;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare score, collision and every row.
  task automatic check_expected(input string tag);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      n_chk++;
      if (score !== e.score) begin
        n_err++;
        $display("FAIL %s score got=%0d exp=%0d", tag, score, e.score);
      end
      n_chk++;
      if (coll !== e.coll) begin
        n_err++;
        $display("FAIL %s collision got=%b exp=%b", tag, coll, e.coll);
      end
      for (int i = 0; i < NR; i++) begin
        rowsel = i[RA-1:0];
        #1;
        n_chk++;
        if (row_out !== e.rows[i]) begin
          n_err++;
          $display("FAIL %s row%0d got=%h exp=%h", tag, i, row_out, e.rows[i]);
        end
      end
      rowsel = 3'd0;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    load_n = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  // One-cycle low pulse, then wait out SHIFT and CHECK.
  task automatic do_load(input string tag);
    load_n = 1'b0;
    tick();
    load_n = 1'b1;
    tick();
    tick();
    model_load();
    push_expected();
    check_expected(tag);
  endtask

  task automatic test_reset();
    player = 8'h00;
    do_reset();
    push_expected();
    check_expected("reset");
    repeat (5) tick();
    push_expected();
    check_expected("idle");
  endtask

  task automatic test_held_low();
    do_reset();
    load_n = 1'b0;
    repeat (10) tick();
    load_n = 1'b1;
    tick();
    model_load();
    push_expected();
    check_expected("held_low");
    n_chk++;
    rowsel = 3'd0;
    #1;
    if (row_out !== 8'h20) begin
      n_err++;
      $display("FAIL held_low_row0 got=%h exp=20", row_out);
    end
  endtask

  task automatic test_first_loads();
    logic [7:0] exp_row0 [3];
    exp_row0[0] = 8'h20;
    exp_row0[1] = 8'h00;
    exp_row0[2] = 8'h20;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      do_load("first_loads");
      rowsel = 3'd0;
      #1;
      n_chk++;
      if (row_out !== exp_row0[k]) begin
        n_err++;
        $display("FAIL first_load%0d_row0 got=%h exp=%h", k + 1, row_out, exp_row0[k]);
      end
    end
    rowsel = 3'd2;
    #1;
    n_chk++;
    if (row_out !== 8'h20) begin
      n_err++;
      $display("FAIL first_loads_row2 got=%h exp=20", row_out);
    end
  endtask

  task automatic test_crash();
    player = 8'h20;
    do_reset();
    for (int k = 0; k < 7; k++) do_load("crash_pre");
    // Load 8: watch collision rise exactly three clocks after the request.
    load_n = 1'b0;
    tick();
    load_n = 1'b1;
    tick();
    n_chk++;
    if (coll !== 1'b0) begin
      n_err++;
      $display("FAIL crash_early got=%b exp=0", coll);
    end
    tick();
    model_load();
    push_expected();
    check_expected("crash_load8");
    n_chk++;
    if (coll !== 1'b1) begin
      n_err++;
      $display("FAIL crash_flag got=%b exp=1", coll);
    end
    for (int k = 0; k < 3; k++) do_load("crash_frozen");
  endtask

  task automatic test_no_crash_score();
    player = 8'h01;
    do_reset();
    for (int k = 0; k < 9; k++) do_load("pass_score");
    n_chk++;
    if (score !== 8'd1 || coll !== 1'b0) begin
      n_err++;
      $display("FAIL pass_score9 got=%0d/%b exp=1/0", score, coll);
    end
    player = 8'h00;
  endtask

  task automatic test_spaced2();
    player = 8'h00;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      load_n = 1'b0;
      tick();
      load_n = 1'b1;
      tick();
      if ((k % 2) == 0) model_load();
    end
    tick();
    push_expected();
    check_expected("spaced2");
  endtask

  task automatic test_saturation();
    player = 8'h00;
    do_reset();
    for (int k = 0; k < 700; k++) do_load("saturate");
    n_chk++;
    if (score !== 8'hFF) begin
      n_err++;
      $display("FAIL saturate_final got=%0d exp=255", score);
    end
  endtask

  task automatic test_reset_mid_shift();
    player = 8'h00;
    do_reset();
    do_load("mid_pre");
    do_load("mid_pre");
    do_load("mid_pre");
    load_n = 1'b0;
    tick();
    // Now in SHIFT; reset before its edge.
    rst = 1'b1;
    #1;
    model_reset();
    push_expected();
    check_expected("mid_reset_async");
    load_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    push_expected();
    check_expected("mid_reset_after");
    do_load("mid_reload");
    rowsel = 3'd0;
    #1;
    n_chk++;
    if (row_out !== 8'h20) begin
      n_err++;
      $display("FAIL mid_reload_row0 got=%h exp=20", row_out);
    end
  endtask

  initial begin
    rst    = 1'b1;
    load_n = 1'b1;
    player = 8'h00;
    rowsel = 3'd0;
    model_reset();
    test_reset();
    test_held_low();
    test_first_loads();
    test_crash();
    test_no_crash_score();
    test_spaced2();
    test_saturation();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
